// File: rtl/commit_tracker_if.sv
// Writeback-to-commit bus: retire inputs from writeback, commit record and
// harness counters out to the difftest bridge.
interface commit_tracker_if;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [31:0] wb_inst;
    logic        wb_mem_en;
    logic [63:0] wb_mem_addr;
    logic [63:0] gpr_a0;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [63:0] commit_inst;
    logic        commit_skip;
    logic [31:0] halt_flag;
    logic        halted;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    modport master (
        output wb_valid, wb_pc, wb_inst, wb_mem_en, wb_mem_addr, gpr_a0,
        input  commit_valid, commit_pc, commit_inst, commit_skip,
        input  halt_flag, halted, cycle_cnt, instret_cnt
    );

    modport slave (
        input  wb_valid, wb_pc, wb_inst, wb_mem_en, wb_mem_addr, gpr_a0,
        output commit_valid, commit_pc, commit_inst, commit_skip,
        output halt_flag, halted, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/commit_tracker.sv
// Retire-side commit tracker: registers each writeback retire as a one-cycle
// commit record, halts on ebreak or watchdog timeout, and keeps cycle/instret counters.
module commit_tracker #(
    parameter logic [63:0] MMIO_BASE = 64'h0000_0000_a000_0000,
    parameter logic [63:0] MMIO_SIZE = 64'h0000_0000_0100_0000,
    parameter logic [31:0] TIMEOUT   = 32'd10000
) (
    input  logic            clk,
    input  logic            rst,
    commit_tracker_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_HALT    = 2'd1,
        S_TIMEOUT = 2'd2
    } state_t;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    state_t      state;
    logic [31:0] wd_cnt;
    logic        accept;

    // Unsigned subtraction folds the lower bound into the compare: addresses
    // below MMIO_BASE wrap to huge values and fail the size check.
    function automatic logic in_mmio(input logic en, input logic [63:0] addr);
        return en && ((addr - MMIO_BASE) < MMIO_SIZE);
    endfunction

    assign accept = (state == S_RUN) && bus.wb_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_RUN;
            wd_cnt           <= 32'd0;
            bus.commit_valid <= 1'b0;
            bus.commit_pc    <= 64'd0;
            bus.commit_inst  <= 64'd0;
            bus.commit_skip  <= 1'b0;
            bus.halt_flag    <= 32'd0;
            bus.halted       <= 1'b0;
            bus.cycle_cnt    <= 64'd0;
            bus.instret_cnt  <= 64'd0;
        end else begin
            bus.commit_valid <= accept;
            bus.commit_skip  <= accept && in_mmio(bus.wb_mem_en, bus.wb_mem_addr);
            if (state == S_RUN) begin
                bus.cycle_cnt <= bus.cycle_cnt + 64'd1;
                // A retire on the limit cycle beats the watchdog.
                if (bus.wb_valid) begin
                    wd_cnt          <= 32'd0;
                    bus.commit_pc   <= bus.wb_pc;
                    bus.commit_inst <= {32'd0, bus.wb_inst};
                    bus.instret_cnt <= bus.instret_cnt + 64'd1;
                    if (bus.wb_inst == EBREAK) begin
                        state         <= S_HALT;
                        bus.halted    <= 1'b1;
                        bus.halt_flag <= {16'd0, bus.gpr_a0[7:0], 8'h01};
                    end
                end else if (wd_cnt == TIMEOUT - 32'd1) begin
                    state         <= S_TIMEOUT;
                    bus.halted    <= 1'b1;
                    bus.halt_flag <= 32'h0000_0002;
                end else begin
                    wd_cnt <= wd_cnt + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_commit_tracker.sv
// Directed and randomized bench for commit_tracker against a behavioural
// model of the retire/halt/watchdog rules.
module tb_commit_tracker;
    localparam logic [63:0] BASE   = 64'h0000_0000_a000_0000;
    localparam logic [63:0] SIZE   = 64'h0000_0000_0100_0000;
    localparam int          TMO    = 8;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    commit_tracker_if bus ();

    commit_tracker #(
        .MMIO_BASE(BASE),
        .MMIO_SIZE(SIZE),
        .TIMEOUT  (32'(TMO))
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic        m_halted;
    int          m_idle;
    logic        m_valid;
    logic        m_skip;
    logic [63:0] m_pc;
    logic [63:0] m_inst;
    logic [31:0] m_flag;
    logic [63:0] m_cycles;
    logic [63:0] m_instret;

    task automatic model_reset();
        m_halted = 0; m_idle = 0; m_valid = 0; m_skip = 0;
        m_pc = 0; m_inst = 0; m_flag = 0; m_cycles = 0; m_instret = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (m_halted) begin
            m_valid = 0;
            m_skip  = 0;
        end else begin
            m_cycles = m_cycles + 1;
            if (bus.wb_valid) begin
                m_valid = 1;
                m_skip  = bus.wb_mem_en && (bus.wb_mem_addr >= BASE) &&
                          (bus.wb_mem_addr < BASE + SIZE);
                m_pc    = bus.wb_pc;
                m_inst  = {32'd0, bus.wb_inst};
                m_instret = m_instret + 1;
                m_idle  = 0;
                if (bus.wb_inst == EBREAK) begin
                    m_halted = 1;
                    m_flag   = 32'h1 | (32'(bus.gpr_a0[7:0]) << 8);
                end
            end else begin
                m_valid = 0;
                m_skip  = 0;
                m_idle  = m_idle + 1;
                if (m_idle == TMO) begin
                    m_halted = 1;
                    m_flag   = 32'h2;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("commit_valid", 64'(bus.commit_valid), 64'(m_valid));
        chk("commit_skip",  64'(bus.commit_skip),  64'(m_skip));
        chk("commit_pc",    bus.commit_pc,         m_pc);
        chk("commit_inst",  bus.commit_inst,       m_inst);
        chk("halt_flag",    64'(bus.halt_flag),    64'(m_flag));
        chk("halted",       64'(bus.halted),       64'(m_halted));
        chk("cycle_cnt",    bus.cycle_cnt,         m_cycles);
        chk("instret_cnt",  bus.instret_cnt,       m_instret);
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                         input logic men, input logic [63:0] addr, input logic [63:0] a0);
        bus.wb_valid    = v;
        bus.wb_pc       = pc;
        bus.wb_inst     = inst;
        bus.wb_mem_en   = men;
        bus.wb_mem_addr = addr;
        bus.gpr_a0      = a0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(0, 64'd0, 32'd0, 0, 64'd0, 64'd0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1;
        idle(2);
        rst = 0;
    endtask

    initial begin
        logic [63:0] addr;
        model_reset();
        drive(0, 64'd0, 32'd0, 0, 64'd0, 64'd0);
        @(negedge clk);
        do_reset();
        chk("reset halted", 64'(bus.halted), 64'd0);
        chk("reset cycle", bus.cycle_cnt, 64'd0);

        // Three plain retires
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'h8000_0000 + 64'(4 * i), 32'h0000_0013, 0, 64'd0, 64'd0);
            tick();
            chk("plain valid", 64'(bus.commit_valid), 64'd1);
        end
        idle(1);
        chk("instret after 3", bus.instret_cnt, 64'd3);

        // MMIO store skips; store just below base wraps and does not
        drive(1, 64'h8000_000c, 32'h00a5_3023, 1, 64'h0000_0000_a000_03f8, 64'd0);
        tick();
        chk("mmio skip", 64'(bus.commit_skip), 64'd1);
        drive(1, 64'h8000_0010, 32'h00a5_3023, 1, 64'h0000_0000_9fff_fff8, 64'd0);
        tick();
        chk("below base skip", 64'(bus.commit_skip), 64'd0);

        // ebreak with exit code 5
        drive(1, 64'h8000_0014, EBREAK, 0, 64'd0, 64'd5);
        tick();
        chk("ebreak inst", bus.commit_inst, 64'h0000_0000_0010_0073);
        chk("ebreak flag", 64'(bus.halt_flag), 64'h0000_0501);
        chk("ebreak halted", 64'(bus.halted), 64'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 64'h8000_0100, 32'h0000_0013, 0, 64'd0, 64'd0);
            tick();
        end
        chk("halt instret hold", bus.instret_cnt, 64'd6);
        chk("halt no commit", 64'(bus.commit_valid), 64'd0);

        // Reset while halted, then a normal retire
        do_reset();
        chk("post-halt reset flag", 64'(bus.halt_flag), 64'd0);
        drive(1, 64'h8000_0000, 32'h0000_0013, 0, 64'd0, 64'd0);
        tick();
        chk("post-reset commit", 64'(bus.commit_valid), 64'd1);

        // Pure timeout
        do_reset();
        idle(TMO);
        chk("timeout halted", 64'(bus.halted), 64'd1);
        chk("timeout flag", 64'(bus.halt_flag), 64'd2);
        idle(5);
        chk("timeout cycle frozen", bus.cycle_cnt, 64'd8);

        // Retire on the limit cycle wins, then a full idle window times out
        do_reset();
        idle(TMO - 1);
        drive(1, 64'h8000_0040, 32'h0000_0013, 0, 64'd0, 64'd0);
        tick();
        chk("limit retire commit", 64'(bus.commit_valid), 64'd1);
        chk("limit retire no halt", 64'(bus.halted), 64'd0);
        idle(TMO - 1);
        chk("window not yet", 64'(bus.halted), 64'd0);
        idle(1);
        chk("window timeout", 64'(bus.halted), 64'd1);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 29) == 0) begin
                idle($urandom_range(6, 10));
            end else begin
                case ($urandom_range(0, 3))
                    0: addr = BASE + 64'($urandom_range(0, 32'h00ff_ffff));
                    1: addr = BASE - 64'($urandom_range(1, 16));
                    2: addr = BASE + SIZE - 64'($urandom_range(0, 2));
                    default: addr = {$urandom, $urandom};
                endcase
                drive($urandom_range(0, 3) != 0, {$urandom, $urandom},
                      ($urandom_range(0, 49) == 0) ? EBREAK : $urandom,
                      1'($urandom_range(0, 1)), addr, {$urandom, $urandom});
                tick();
            end
            if (m_halted && $urandom_range(0, 5) == 0) do_reset();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
